// File: rtl/wr_resp_buf_if.sv
// B-channel bundle for wr_resp_buf: slave-side inputs (_s) and demux-side outputs (_m).
// The buffer uses the slave modport, and the surrounding environment uses the master modport.
interface wr_resp_buf_if #(
   parameter int unsigned ID_W = 4
);
   logic [ID_W-1:0] bid_s;
   logic [1:0]      bresp_s;
   logic            bvalid_s;
   logic            bready_s;
   logic [ID_W-1:0] bid_m;
   logic [1:0]      bresp_m;
   logic            bvalid_m;
   logic            bready_m;

   modport slave (
      input  bid_s, bresp_s, bvalid_s, bready_m,
      output bready_s, bid_m, bresp_m, bvalid_m
   );

   modport master (
      output bid_s, bresp_s, bvalid_s, bready_m,
      input  bready_s, bid_m, bresp_m, bvalid_m
   );
endinterface

// File: rtl/wr_resp_buf.sv
// In-order write-response buffer: stores up to DEPTH {bid, bresp} beats and presents the oldest one to the demux.
// bready_s is registered, so a pop while full does not admit a push in the same cycle.
module wr_resp_buf #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 4
) (
   input  logic                     aclk,
   input  logic                     areset,
   wr_resp_buf_if.slave             b,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = ID_W + 2;
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_nxt;
   logic          ready_q;
   logic          push;
   logic          pop;

   assign push = b.bvalid_s & ready_q;
   assign pop  = b.bvalid_m & b.bready_m;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_ONE;
      else if (pop && !push)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= {b.bid_s, b.bresp_s};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         count   <= count_nxt;
         ready_q <= (count_nxt < CNT_FULL);
      end
   end

   assign b.bready_s            = ready_q;
   assign b.bvalid_m            = (count != '0);
   assign {b.bid_m, b.bresp_m}  = mem[rd_ptr];
endmodule

// File: tb/tb_wr_resp_buf.sv
// Bench for wr_resp_buf: fixed vector table, directed corner sequences and random traffic
// checked against a queue-based model of the buffer.
module tb_wr_resp_buf;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned ID_W  = 4;

   logic       aclk   = 1'b0;
   logic       areset = 1'b0;
   logic [2:0] count;

   wr_resp_buf_if #(.ID_W(ID_W)) bif ();

   wr_resp_buf #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .aclk   (aclk),
      .areset (areset),
      .b      (bif),
      .count  (count)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       bvs;
      logic [3:0] id;
      logic [1:0] rsp;
      logic       brm;
      logic       e_rdy;
      logic       e_vld;
      logic [3:0] e_id;
      logic [1:0] e_rsp;
      int         e_cnt;
   } vec_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] rsp;
   } beat_t;

   vec_t  tbl [16];
   beat_t q [$];
   logic  m_rdy = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic bvs, input logic [3:0] id, input logic [1:0] rsp, input logic brm);
      bif.bvalid_s = bvs;
      bif.bid_s    = id;
      bif.bresp_s  = rsp;
      bif.bready_m = brm;
   endtask

   // Model: the slave's beat is taken when the previous cycle's ready was high, and the head leaves when it is non-empty and accepted.
   task automatic model_edge();
      logic  psh;
      logic  pp;
      beat_t nb;
      psh = bif.bvalid_s & m_rdy;
      pp  = (q.size() != 0) && bif.bready_m;
      nb.id  = bif.bid_s;
      nb.rsp = bif.bresp_s;
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(nb);
      m_rdy = (q.size() < DEPTH);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".bready_s"}, int'(bif.bready_s), int'(m_rdy));
      chk({tag, ".bvalid_m"}, int'(bif.bvalid_m), int'(q.size() != 0));
      chk({tag, ".count"}, int'(count), q.size());
      if (q.size() != 0) begin
         chk({tag, ".bid_m"}, int'(bif.bid_m), int'(q[0].id));
         chk({tag, ".bresp_m"}, int'(bif.bresp_m), int'(q[0].rsp));
      end
   endtask

   task automatic cycle(input string tag, input logic bvs, input logic [3:0] id,
                        input logic [1:0] rsp, input logic brm);
      drive(bvs, id, rsp, brm);
      @(posedge aclk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      areset = 1'b0;
      q.delete();
      m_rdy = 1'b0;
      drive(1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      #1;
      chk("rst.bready_s", int'(bif.bready_s), 0);
      chk("rst.bvalid_m", int'(bif.bvalid_m), 0);
      chk("rst.bid_m", int'(bif.bid_m), 0);
      chk("rst.bresp_m", int'(bif.bresp_m), 0);
      chk("rst.count", int'(count), 0);
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_hold.bready_s", int'(bif.bready_s), 0);
      chk("rst_hold.count", int'(count), 0);
      areset = 1'b1;
      #1;
      chk("rst_rel.bready_s", int'(bif.bready_s), 0);
      cycle("rst_first_edge", 1'b0, 4'h0, 2'b00, 1'b0);
      chk("rst_first_edge.ready_is_1", int'(bif.bready_s), 1);
   endtask

   initial begin
      logic       pend;
      logic [3:0] pid;
      logic [1:0] prsp;
      logic       rdy_before;
      int         bias;

      // bvs, id, rsp, brm | e_rdy, e_vld, e_id, e_rsp, e_cnt (after the edge)
      tbl[0]  = '{1'b1, 4'd2,  2'd0, 1'b1, 1'b1, 1'b1, 4'd2,  2'd0, 1};
      tbl[1]  = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0,  2'd0, 0};
      tbl[2]  = '{1'b1, 4'd5,  2'd1, 1'b0, 1'b1, 1'b1, 4'd5,  2'd1, 1};
      tbl[3]  = '{1'b1, 4'd6,  2'd2, 1'b0, 1'b1, 1'b1, 4'd5,  2'd1, 2};
      tbl[4]  = '{1'b1, 4'd7,  2'd3, 1'b0, 1'b1, 1'b1, 4'd5,  2'd1, 3};
      tbl[5]  = '{1'b1, 4'd8,  2'd0, 1'b0, 1'b0, 1'b1, 4'd5,  2'd1, 4};
      tbl[6]  = '{1'b1, 4'd9,  2'd1, 1'b0, 1'b0, 1'b1, 4'd5,  2'd1, 4};
      tbl[7]  = '{1'b1, 4'd9,  2'd1, 1'b1, 1'b1, 1'b1, 4'd6,  2'd2, 3};
      tbl[8]  = '{1'b1, 4'd9,  2'd1, 1'b0, 1'b0, 1'b1, 4'd6,  2'd2, 4};
      tbl[9]  = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b1, 4'd7,  2'd3, 3};
      tbl[10] = '{1'b1, 4'd10, 2'd2, 1'b1, 1'b1, 1'b1, 4'd8,  2'd0, 3};
      tbl[11] = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b1, 4'd9,  2'd1, 2};
      tbl[12] = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b1, 4'd10, 2'd2, 1};
      tbl[13] = '{1'b1, 4'd11, 2'd3, 1'b1, 1'b1, 1'b1, 4'd11, 2'd3, 1};
      tbl[14] = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0,  2'd0, 0};
      tbl[15] = '{1'b0, 4'd0,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0,  2'd0, 0};

      do_reset();

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].bvs, tbl[i].id, tbl[i].rsp, tbl[i].brm);
         @(posedge aclk);
         model_edge();
         #1;
         chk($sformatf("tbl%0d.bready_s", i), int'(bif.bready_s), int'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d.bvalid_m", i), int'(bif.bvalid_m), int'(tbl[i].e_vld));
         chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].e_cnt);
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d.bid_m", i), int'(bif.bid_m), int'(tbl[i].e_id));
            chk($sformatf("tbl%0d.bresp_m", i), int'(bif.bresp_m), int'(tbl[i].e_rsp));
         end
      end

      // Single-beat latency
      cycle("lat_push", 1'b1, 4'h2, 2'b00, 1'b1);
      chk("lat.vld_n1", int'(bif.bvalid_m), 1);
      chk("lat.bid_n1", int'(bif.bid_m), 2);
      cycle("lat_pop", 1'b0, 4'h0, 2'b00, 1'b1);
      chk("lat.vld_n2", int'(bif.bvalid_m), 0);

      // Steady push/pop at count 2; pointers wrap twice over 8 cycles
      cycle("pp_fill0", 1'b1, 4'hA, 2'b01, 1'b0);
      cycle("pp_fill1", 1'b1, 4'hB, 2'b10, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cycle($sformatf("pp%0d", k), 1'b1, 4'(k), 2'(k), 1'b1);
         chk($sformatf("pp%0d.count2", k), int'(count), 2);
      end
      cycle("pp_drain0", 1'b0, 4'h0, 2'b00, 1'b1);
      cycle("pp_drain1", 1'b0, 4'h0, 2'b00, 1'b1);

      // Mid-operation reset with SLVERR at the head
      cycle("mr_push0", 1'b1, 4'h3, 2'b10, 1'b0);
      cycle("mr_push1", 1'b1, 4'h4, 2'b01, 1'b0);
      cycle("mr_push2", 1'b1, 4'h5, 2'b11, 1'b0);
      chk("mr.head_resp", int'(bif.bresp_m), 2);
      #3;
      areset = 1'b0;
      #1;
      chk("mr.bvalid_m", int'(bif.bvalid_m), 0);
      chk("mr.count", int'(count), 0);
      chk("mr.bready_s", int'(bif.bready_s), 0);
      q.delete();
      m_rdy = 1'b0;
      #1;
      areset = 1'b1;
      for (int k = 0; k < 3; k++)
         cycle($sformatf("mr_after%0d", k), 1'b0, 4'h0, 2'b00, 1'b1);

      // Random traffic; the slave holds an unaccepted beat
      pend = 1'b0;
      pid  = '0;
      prsp = '0;
      bias = 50;
      for (int n = 0; n < 800; n++) begin
         if (n % 100 == 0) bias = $urandom_range(10, 95);
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend = 1'b1;
            pid  = 4'($urandom);
            prsp = 2'($urandom);
         end
         rdy_before = m_rdy;
         cycle("rnd", pend, pend ? pid : 4'($urandom), pend ? prsp : 2'($urandom),
               ($urandom_range(0, 99) < bias));
         if (pend && rdy_before) pend = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wr_resp_buf.md
# wr_resp_buf

Write-response (B channel) buffer between an AXI slave's B port and the 1-to-2 write-response demux in the master router. It stores up to DEPTH response beats in order, decoupling slave backpressure from master readiness, and presents them unchanged (ID, response) to the demux input. It does no routing: the demux routes each beat on ID bit 1 downstream.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2
- ID_W, 4: response ID width
- aclk  input  1  clock; all state changes on rising edge
- areset  input  1  asynchronous, active-low reset
- bid_s  input  ID_W  response ID from slave
- bresp_s  input  2  response code from slave
- bvalid_s  input  1  slave beat valid
- bready_s  output  1  buffer can accept a beat
- bid_m  output  ID_W  head-entry ID to demux
- bresp_m  output  2  head-entry response to demux
- bvalid_m  output  1  head entry valid
- bready_m  input  1  demux accepts head entry
- count  output  clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH-entry circular array of {bid, bresp}. Write pointer wr_ptr and read pointer rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH (DEPTH-1 → 0).
- Push: bvalid_s & bready_s at a rising edge writes {bid_s, bresp_s} to mem[wr_ptr], then wr_ptr+1.
- Pop: bvalid_m & bready_m at a rising edge increments rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH; never over- or underflows.
- bready_s is a register: 1 when the next-state count < DEPTH, else 0. No same-cycle pass-through when full: a pop while full does not admit a push in that cycle.
- bvalid_m = (count != 0). bid_m/bresp_m = mem[rd_ptr]. No bypass when empty: data reaches the output only after it is written.
- Order is strict FIFO; IDs and response codes pass through unmodified, including SLVERR/DECERR.
- Head data and bvalid_m stay stable while bvalid_m & !bready_m.
- bready_m is ignored when bvalid_m = 0. bvalid_s is ignored when bready_s = 0; the slave holds the beat.

## Timing
- Reset (areset low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, all entries cleared to 0, bready_s = 0, bvalid_m = 0, bid_m = 0, bresp_m = 0.
- Reset deassertion: bready_s rises at the first rising edge after areset goes high.
- Latency: a beat pushed at edge N appears with bvalid_m = 1 after edge N (visible in cycle N+1). Minimum slave-to-master latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full: the push that makes count = DEPTH drops bready_s after the same edge. bready_s returns to 1 after the first edge with a pop and no push.
- Empty: the pop that makes count = 0 drops bvalid_m after that edge. A simultaneous push at count = 1 keeps bvalid_m = 1, and the new beat becomes the head.
- Reset mid-operation: all buffered beats are discarded immediately, and outputs take their reset values asynchronously.

## Test plan
- Reset values: hold areset low with random inputs. Required: bready_s = 0, bvalid_m = 0, bid_m = 0, bresp_m = 0, count = 0. Release reset. Required: bready_s = 1 after the first edge.
- Single-beat latency: push bid_s = 4'h2, bresp_s = 2'b00 at edge N with bready_m = 1. Required: bvalid_m = 1, bid_m = 4'h2 in cycle N+1; popped at edge N+1; bvalid_m = 0 in cycle N+2.
- Fill and backpressure: bready_m = 0, push IDs 0,1,2,3 on consecutive edges. Required: count = 4 and bready_s = 0 after the 4th push; a 5th beat on bvalid_s is held, not stored; bid_m = 0 throughout.
- Drain after full: from the full state, assert bready_m for 1 cycle. Required: bready_s = 1 next cycle, count = 3, head bid_m = 1. The held 5th beat (ID 4) is accepted and emerges after ID 3.
- Simultaneous push/pop: at count = 2, push and pop every cycle for 8 cycles. Required: count stays 2; output order equals input order; pointers wrap twice.
- Mid-operation reset: with count = 3 and bresp = 2'b10 at the head, pulse areset low between edges. Required: bvalid_m = 0 and count = 0 immediately; after release, no stale beat is emitted.
